// File: rtl/core_run_if.sv
// Run-control bundle between a run requester and core_run_ctrl.
// The requester drives start/mask and relays the cores' OPEND flags.
interface core_run_if #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic [NUM_CORES-1:0] core_mask;
  logic [NUM_CORES-1:0] opend;
  logic [NUM_CORES-1:0] en;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic [NUM_CORES-1:0] core_done;
  logic [CNT_W-1:0]     cycle_count;

  modport master (
    output start, core_mask, opend,
    input  en, busy, done, timeout, core_done, cycle_count
  );

  modport slave (
    input  start, core_mask, opend,
    output en, busy, done, timeout, core_done, cycle_count
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Run controller for the multi-core processor: launches a masked set of cores,
// drops each core's clock enable at its OPEND, and reports completion/timeout.
module core_run_ctrl #(
  parameter int NUM_CORES      = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  core_run_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [NUM_CORES-1:0] mask_q;
  logic [NUM_CORES-1:0] en_q;
  logic [NUM_CORES-1:0] core_done_q;
  logic [CNT_W-1:0]     cycle_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 timeout_q;

  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] done_next;
  logic                 all_done;
  logic                 wd_fire;
  logic [CNT_W-1:0]     cycle_inc;

  // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    hit       = en_q & bus.opend;   // only enabled cores can finish
    done_next = core_done_q | hit;
    all_done  = (done_next == mask_q);
    wd_fire   = (TIMEOUT_CYCLES != 0) && (cycle_q == WD_LAST);
    cycle_inc = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mask_q      <= '0;
      en_q        <= '0;
      core_done_q <= '0;
      cycle_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && (|bus.core_mask)) begin
            mask_q      <= bus.core_mask;
            core_done_q <= '0;
            cycle_q     <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          en_q  <= mask_q;
          state <= RUN;
        end
        RUN: begin
          cycle_q     <= cycle_inc;
          core_done_q <= done_next;
          // Completion is checked first so a last finish on the watchdog edge is not a timeout.
          if (all_done) begin
            en_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FINISH;
          end else if (wd_fire) begin
            en_q      <= '0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state     <= FINISH;
          end else begin
            en_q <= en_q & ~hit;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.en          = en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.core_done   = core_done_q;
  assign bus.cycle_count = cycle_q;

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Upstream run controller for the quad-core processor: it generates the per-core enables `en[3:0]` that gate `clk1..clk4`.
- Accepts a start command with a core mask.
- Enables the selected cores and watches each core's `OPEND` end-of-operation flag.
- Drops each core's enable as that core finishes.
- Reports completion, per-core status, elapsed cycles and an optional watchdog timeout.

Parameters:
NUM_CORES, 4, number of cores controlled (en/opend/mask width).
CNT_W, 16, width of cycle_count.
TIMEOUT_CYCLES, 0, watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
clk  input  1  system clock (ungated).
rst  input  1  synchronous, active-high reset.
start  input  1  run request; sampled on rising clk.
core_mask  input  NUM_CORES  cores to run; latched when start is accepted.
opend  input  NUM_CORES  OPEND flags from the cores, level-sensitive.
en  output  NUM_CORES  registered clock-enable per core, to the clock-gating logic.
busy  output  1  run in progress (LAUNCH or RUN).
done  output  1  one-cycle pulse at end of run.
timeout  output  1  sticky: last run ended by watchdog.
core_done  output  NUM_CORES  sticky per-core finished flags for the current/last run.
cycle_count  output  CNT_W  RUN cycles elapsed, saturating at all-ones.

Behaviour:
- Reset (rst=1 at an edge) forces these values; this applies identically mid-run, and the run is abandoned with no done pulse:
  - state=IDLE
  - en=0, busy=0, done=0, timeout=0
  - core_done=0, cycle_count=0, latched mask=0
- All outputs are registered.
- States are IDLE, LAUNCH, RUN and FINISH.

IDLE:
- On an edge where start=1 and core_mask≠0: latch the mask; clear core_done, cycle_count and timeout; go to LAUNCH.
- On an edge where start=1 and core_mask=0: ignore the request; stay in IDLE; do not pulse done.

LAUNCH:
- Lasts exactly one cycle; busy=1, en=0.
- opend is ignored here, so stale flags from the previous run have no effect.
- Next state is RUN.
- On entry to RUN, en=latched mask.

RUN:
- busy=1; cycle_count increments by 1 per edge, saturating.
- For each core i with en[i]=1 and opend[i]=1 at an edge:
  - core_done[i] is set after that edge;
  - en[i] is cleared after that edge.
- Several cores may finish on the same edge.
- opend[i] is ignored when en[i]=0, whether the core is unmasked or already done.
- When the updated core_done equals the latched mask, go to FINISH on that same edge.
- Watchdog: if TIMEOUT_CYCLES≠0 and cycle_count = TIMEOUT_CYCLES-1 at an edge with any masked core still not done, then after that edge:
  - en=0, timeout=1, state=FINISH.
- If the last core finishes on the same edge the watchdog would fire, completion wins and timeout stays 0.

FINISH:
- done=1 and busy=0 for exactly one cycle; en=0.
- Next state is IDLE.
- core_done, cycle_count and timeout hold until the next accepted start.

Other rules:
- start is ignored while not in IDLE, including in FINISH.
- An opend bit that stays high after its core is done has no further effect.

Test Plan:
- Single core: rst 1 cycle; start=1, mask=4'b0001 at edge 0; opend[0]=1 before edge 5.
  -> busy=1 after edge 0.
  -> en=0001 after edges 1–4.
  -> after edge 5: en=0, core_done=0001, cycle_count=4.
  -> done=1 for exactly the cycle after edge 5; busy=0 then.
- Staggered finish, mask=1111: opend[2] at edge 3, opend[0]&opend[3] at edge 5, opend[1] at edge 8.
  -> en goes 1111 → 1011 → 0010 → 0000.
  -> core_done=1111 and done pulses once, after edge 8.
- Masked and stale flags: opend=1111 held high before start; mask=0101.
  -> LAUNCH ignores opend.
  -> run finishes on the first RUN edge; opend[1] and opend[3] have no effect.
  -> core_done=0101.
- Watchdog: TIMEOUT_CYCLES=10, mask=0011, only opend[0] asserts.
  -> after RUN edge 10: en=0, timeout=1, core_done=0001, cycle_count=10.
  -> done pulses once.
- Illegal starts: start with mask=0 in IDLE -> no state change, no done. start during RUN with a new mask -> ignored; latched mask unchanged.
- Reset mid-run: rst=1 while in RUN with en=0110 -> after that edge, all outputs are 0, state IDLE, no done pulse; a subsequent start runs normally.
